// File: rtl/preset_seq.sv
// preset_seq: drives active-low SETB and clock enables for NBANK preset flop banks; define PRESET_SEQ_STAGGER_EN to preset banks one at a time
module preset_seq #(
  parameter int NBANK   = 4,
  parameter int PW_CYC  = 2,
  parameter int REC_CYC = 2,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [NBANK-1:0] setb_out,
  output logic [NBANK-1:0] clken,
  output logic             busy,
  output logic             done
);
  localparam int MX0 = PW_CYC > REC_CYC ? PW_CYC : REC_CYC;
  localparam int MX  = MX0 > GAP_CYC ? MX0 : GAP_CYC;
  localparam int CW  = $clog2(MX + 1);
  localparam logic [CW-1:0] PW_END  = CW'(PW_CYC - 1);
  localparam logic [CW-1:0] REC_END = CW'(REC_CYC - 1);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
`ifdef PRESET_SEQ_STAGGER_EN
  localparam logic [1:0] S_GAP = 2'd3;
  localparam int IW = NBANK > 1 ? $clog2(NBANK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBANK - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  localparam logic [NBANK-1:0] ONE = NBANK'(1);
  logic [IW-1:0] idx;
  // per-bank sequencer: only bank idx is ever held low, so SETB is rebuilt from a single-hot mask
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      setb_out <= '1;
      clken    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (busy && abort) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      setb_out <= '1;
      clken    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_ASSERT;
          idx      <= '0;
          cnt      <= '0;
          setb_out <= ~ONE;
          clken    <= '0;
          busy     <= 1'b1;
        end
        S_ASSERT: if (cnt == PW_END) begin
          state    <= S_RECOVER;
          cnt      <= '0;
          setb_out <= '1;
        end else cnt <= cnt + 1'b1;
        S_RECOVER: if (cnt == REC_END) begin
          cnt   <= '0;
          clken <= clken | (ONE << idx);
          if (idx == LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (GAP_CYC == 0) begin
            state    <= S_ASSERT;
            idx      <= idx + 1'b1;
            setb_out <= ~(ONE << (idx + 1'b1));
          end else state <= S_GAP;
        end else cnt <= cnt + 1'b1;
        S_GAP: if (cnt == GAP_END) begin
          state    <= S_ASSERT;
          cnt      <= '0;
          idx      <= idx + 1'b1;
          setb_out <= ~(ONE << (idx + 1'b1));
        end else cnt <= cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
`else
  // grouped sequencer: all banks are set and released together
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      setb_out <= '1;
      clken    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (busy && abort) begin
      state    <= S_IDLE;
      cnt      <= '0;
      setb_out <= '1;
      clken    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_ASSERT;
          cnt      <= '0;
          setb_out <= '0;
          clken    <= '0;
          busy     <= 1'b1;
        end
        S_ASSERT: if (cnt == PW_END) begin
          state    <= S_RECOVER;
          cnt      <= '0;
          setb_out <= '1;
        end else cnt <= cnt + 1'b1;
        S_RECOVER: if (cnt == REC_END) begin
          state <= S_IDLE;
          cnt   <= '0;
          clken <= '1;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
`endif
endmodule
